// File: rtl/afifo_gray_ctrl_if.sv
// ---------------------------------------------------------------------------
// afifo_gray_ctrl_if
//  Bundles the request/grant, RAM address, flag and occupancy signals of the
//  dual-clock FIFO pointer controller. Write-side and read-side signals share
//  one bundle; each belongs to the clock domain named in the port summary.
//
//  Signals
//   wen        write request                (write domain)
//   wen_allow  accepted write / RAM we      (write domain)
//   waddr      RAM write address            (write domain)
//   alfull     almost full                  (write domain)
//   full       full                         (write domain)
//   wr_deep    write-side occupancy         (write domain)
//   ren        read request                 (read domain)
//   ren_allow  accepted read                (read domain)
//   raddr      RAM read address             (read domain)
//   alempty    almost empty                 (read domain)
//   empty      empty                        (read domain)
//   rd_deep    read-side occupancy          (read domain)
//
//  Modports
//   master : the FIFO user, drives wen/ren and observes everything else
//   slave  : the controller
// ---------------------------------------------------------------------------
interface afifo_gray_ctrl_if #(
   parameter int WIDTH_ADDR = 9
);
   logic                  wen;
   logic                  wen_allow;
   logic [WIDTH_ADDR-1:0] waddr;
   logic                  alfull;
   logic                  full;
   logic [WIDTH_ADDR-1:0] wr_deep;
   logic                  ren;
   logic                  ren_allow;
   logic [WIDTH_ADDR-1:0] raddr;
   logic                  alempty;
   logic                  empty;
   logic [WIDTH_ADDR-1:0] rd_deep;

   modport master (
      output wen, ren,
      input  wen_allow, waddr, alfull, full, wr_deep,
      input  ren_allow, raddr, alempty, empty, rd_deep
   );

   modport slave (
      input  wen, ren,
      output wen_allow, waddr, alfull, full, wr_deep,
      output ren_allow, raddr, alempty, empty, rd_deep
   );
endinterface

// File: rtl/afifo_gray_ctrl.sv
// ---------------------------------------------------------------------------
// afifo_gray_ctrl
//  Pointer and flag controller for a dual-clock FIFO built around an external
//  1R1W RAM. Each domain keeps a (WIDTH_ADDR+1)-bit binary pointer plus a
//  registered gray copy; the gray copy crosses into the other domain through
//  FIFO_SYNC_LEVEL flops and is converted back to binary there. The extra
//  pointer bit separates "full" (MSBs differ, low bits equal) from "empty".
//
//  Ports
//   wrclock  write clock
//   wr_rst   write-domain reset, asynchronous, active-high
//   rdclock  read clock
//   rd_rst   read-domain reset, asynchronous, active-high
//   bus      afifo_gray_ctrl_if.slave: wen/wen_allow/waddr/alfull/full/wr_deep
//            in the write domain, ren/ren_allow/raddr/alempty/empty/rd_deep in
//            the read domain
//
//  WIDTH_DATA is carried for documentation of the attached RAM only.
// ---------------------------------------------------------------------------
module afifo_gray_ctrl #(
   parameter int WIDTH_DATA      = 36,
   parameter int WIDTH_ADDR      = 9,
   parameter int WATERAGE_UP     = 1,
   parameter int WATERAGE_DOWN   = 1,
   parameter int SHOW_AHEAD      = 1,
   parameter int OVERLIMIT_CHECK = 1,
   parameter int OUT_REGISTERED  = 0,
   parameter int FIFO_SYNC_LEVEL = 2
) (
   input  logic                wrclock,
   input  logic                wr_rst,
   input  logic                rdclock,
   input  logic                rd_rst,
   afifo_gray_ctrl_if.slave    bus
);

   localparam int PW = WIDTH_ADDR + 1;
   localparam logic [PW-1:0] DEPTH_CNT   = {1'b1, {WIDTH_ADDR{1'b0}}};
   localparam logic [PW-1:0] ALFULL_LVL  = DEPTH_CNT - PW'(WATERAGE_UP);
   localparam logic [PW-1:0] ALEMPTY_LVL = PW'(WATERAGE_DOWN);

   // Parameter sanity, caught at elaboration time.
   if (WIDTH_ADDR < 3 || WIDTH_ADDR > 32) begin : g_bad_width_addr
      $error("afifo_gray_ctrl: WIDTH_ADDR must be within 3..32");
   end
   if (FIFO_SYNC_LEVEL < 2) begin : g_bad_sync
      $error("afifo_gray_ctrl: FIFO_SYNC_LEVEL must be at least 2");
   end
   if (OUT_REGISTERED < 0 || OUT_REGISTERED > 2) begin : g_bad_outreg
      $error("afifo_gray_ctrl: OUT_REGISTERED must be 0, 1 or 2");
   end
   if (WIDTH_DATA < 1) begin : g_bad_data
      $error("afifo_gray_ctrl: WIDTH_DATA must be positive");
   end

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Occupancy outputs are one bit narrower than the count, so a completely
   // full FIFO reads back as DEPTH-1.
   function automatic logic [WIDTH_ADDR-1:0] sat_deep(input logic [PW-1:0] c);
      return c[WIDTH_ADDR] ? {WIDTH_ADDR{1'b1}} : c[WIDTH_ADDR-1:0];
   endfunction

   // ------------------------------------------------------------------
   // Write domain
   // ------------------------------------------------------------------
   logic [PW-1:0]         wptr_q;
   logic [PW-1:0]         wgray_q;
   logic [PW-1:0]         wsync_q [FIFO_SYNC_LEVEL];
   logic [PW-1:0]         wptr_next;
   logic [PW-1:0]         rptr_sync;
   logic [PW-1:0]         wr_count_next;
   logic                  wen_allow_int;
   logic                  full_q;
   logic                  alfull_q;
   logic [WIDTH_ADDR-1:0] wr_deep_q;

   // Read-domain gray pointer, declared here because it feeds the write sync.
   logic [PW-1:0]         rgray_q;

   assign wen_allow_int = (OVERLIMIT_CHECK != 0) ? (bus.wen & ~full_q) : bus.wen;
   assign wptr_next     = wptr_q + PW'(wen_allow_int);
   assign rptr_sync     = gray2bin(wsync_q[FIFO_SYNC_LEVEL-1]);
   // The synchronised read pointer lags the real one, so this count can only
   // overestimate the fill level: full is conservative.
   assign wr_count_next = wptr_next - rptr_sync;

   // Write pointer, its gray copy, the read-pointer synchroniser and the
   // write-side flags, all evaluated from the post-write pointer so that full
   // rises on the same edge as the write that fills the last slot.
   always_ff @(posedge wrclock or posedge wr_rst) begin
      if (wr_rst) begin
         wptr_q    <= '0;
         wgray_q   <= '0;
         full_q    <= 1'b0;
         alfull_q  <= 1'b0;
         wr_deep_q <= '0;
         for (int i = 0; i < FIFO_SYNC_LEVEL; i++) begin
            wsync_q[i] <= '0;
         end
      end else begin
         wptr_q     <= wptr_next;
         wgray_q    <= bin2gray(wptr_next);
         wsync_q[0] <= rgray_q;
         for (int i = 1; i < FIFO_SYNC_LEVEL; i++) begin
            wsync_q[i] <= wsync_q[i-1];
         end
         full_q    <= (wr_count_next == DEPTH_CNT);
         alfull_q  <= (wr_count_next >= ALFULL_LVL);
         wr_deep_q <= sat_deep(wr_count_next);
      end
   end

   assign bus.wen_allow = wen_allow_int;
   assign bus.waddr     = wptr_q[WIDTH_ADDR-1:0];
   assign bus.full      = full_q;
   assign bus.alfull    = alfull_q;
   assign bus.wr_deep   = wr_deep_q;

   // ------------------------------------------------------------------
   // Read domain
   // ------------------------------------------------------------------
   logic [PW-1:0]         rptr_q;
   logic [PW-1:0]         rsync_q [FIFO_SYNC_LEVEL];
   logic [PW-1:0]         rptr_next;
   logic [PW-1:0]         wptr_sync;
   logic [PW-1:0]         rd_count_next;
   logic                  ren_allow_int;
   logic                  empty_q;
   logic                  empty_hold_q;
   logic                  empty_int;
   logic                  alempty_q;
   logic [WIDTH_ADDR-1:0] rd_deep_q;

   // With a registered RAM output the data needs one more rdclock to reach
   // the user, so empty is held one extra cycle on its way down. Rising empty
   // is never delayed.
   assign empty_int     = empty_q | ((OUT_REGISTERED != 0) & empty_hold_q);
   assign ren_allow_int = (OVERLIMIT_CHECK != 0) ? (bus.ren & ~empty_int) : bus.ren;
   assign rptr_next     = rptr_q + PW'(ren_allow_int);
   assign wptr_sync     = gray2bin(rsync_q[FIFO_SYNC_LEVEL-1]);
   // The synchronised write pointer lags, so this count can only
   // underestimate the fill level: empty is conservative.
   assign rd_count_next = wptr_sync - rptr_next;

   // Read pointer, its gray copy, the write-pointer synchroniser and the
   // read-side flags, evaluated from the post-read pointer so that empty rises
   // on the same edge as the read that takes the last word.
   always_ff @(posedge rdclock or posedge rd_rst) begin
      if (rd_rst) begin
         rptr_q       <= '0;
         rgray_q      <= '0;
         empty_q      <= 1'b1;
         empty_hold_q <= 1'b1;
         alempty_q    <= 1'b1;
         rd_deep_q    <= '0;
         for (int i = 0; i < FIFO_SYNC_LEVEL; i++) begin
            rsync_q[i] <= '0;
         end
      end else begin
         rptr_q     <= rptr_next;
         rgray_q    <= bin2gray(rptr_next);
         rsync_q[0] <= wgray_q;
         for (int i = 1; i < FIFO_SYNC_LEVEL; i++) begin
            rsync_q[i] <= rsync_q[i-1];
         end
         empty_q      <= (rd_count_next == '0);
         empty_hold_q <= empty_q;
         alempty_q    <= (rd_count_next <= ALEMPTY_LVL);
         rd_deep_q    <= sat_deep(rd_count_next);
      end
   end

   // In show-ahead mode the RAM is addressed with the pointer the read is
   // about to produce, so the next head word is already being fetched on the
   // edge that consumes the current one.
   assign bus.raddr     = (SHOW_AHEAD != 0) ? rptr_next[WIDTH_ADDR-1:0]
                                            : rptr_q[WIDTH_ADDR-1:0];
   assign bus.ren_allow = ren_allow_int;
   assign bus.empty     = empty_int;
   assign bus.alempty   = alempty_q;
   assign bus.rd_deep   = rd_deep_q;

endmodule

// File: tb/tb_afifo_gray_ctrl.sv
// ---------------------------------------------------------------------------
// tb_afifo_gray_ctrl
//  Bench for the dual-clock FIFO controller with WIDTH_ADDR=4 (DEPTH 16),
//  show-ahead addressing and a 3:7 wr:rd clock period ratio. A small RAM
//  model sits beside the controller. The reference model is counting only:
//  the k-th accepted write carries word dataFor(k), so the k-th accepted read
//  must present dataFor(k) at address k mod DEPTH.
// ---------------------------------------------------------------------------
module tb_afifo_gray_ctrl;

   localparam int WA    = 4;
   localparam int DEPTH = 16;
   localparam int NRAND = 10000;

   logic        wrclock;
   logic        rdclock;
   logic        wr_rst;
   logic        rd_rst;
   logic [35:0] wdata;
   logic [35:0] mem [DEPTH];
   logic [35:0] dout;
   logic [31:0] salt;

   int tests_run;
   int tests_failed;
   int wr_acc;
   int rd_acc;
   int n;

   afifo_gray_ctrl_if #(.WIDTH_ADDR(WA)) bus ();

   afifo_gray_ctrl #(
      .WIDTH_DATA(36),
      .WIDTH_ADDR(WA),
      .WATERAGE_UP(1),
      .WATERAGE_DOWN(1),
      .SHOW_AHEAD(1),
      .OVERLIMIT_CHECK(1),
      .OUT_REGISTERED(0),
      .FIFO_SYNC_LEVEL(2)
   ) dut (
      .wrclock(wrclock),
      .wr_rst(wr_rst),
      .rdclock(rdclock),
      .rd_rst(rd_rst),
      .bus(bus)
   );

   // Write clock period 60, read clock period 140, read clock offset so the
   // two never share an edge.
   initial begin
      wrclock = 1'b0;
      forever #30 wrclock = ~wrclock;
   end

   initial begin
      rdclock = 1'b0;
      #11;
      forever #70 rdclock = ~rdclock;
   end

   // Synchronous-read RAM output register, addressed by raddr.
   always @(posedge rdclock) begin
      dout <= mem[bus.raddr];
   end

   function automatic logic [35:0] dataFor(input int seq);
      return {4'h5, 32'(seq) ^ salt};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic writeCycle(input bit w);
      @(posedge wrclock);
      #1;
      bus.wen = w;
      wdata   = dataFor(wr_acc);
      @(negedge wrclock);
      #1;
   endtask

   task automatic readCycle(input bit r);
      @(posedge rdclock);
      #1;
      bus.ren = r;
      @(negedge rdclock);
      #1;
   endtask

   task automatic doReset();
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      wr_rst  = 1'b1;
      rd_rst  = 1'b1;
      repeat (3) @(posedge rdclock);
      #1;
      wr_rst = 1'b0;
      rd_rst = 1'b0;
   endtask

   task automatic fillTo(input int target);
      int k;
      k = 0;
      while (wr_acc < target && k < 400) begin
         writeCycle(1'b1);
         k++;
      end
      writeCycle(1'b0);
      checkOutput("fill_count", 64'(wr_acc), 64'(target));
   endtask

   task automatic drainTo(input int target);
      int k;
      k = 0;
      while (rd_acc < target && k < 200) begin
         readCycle(1'b1);
         k++;
      end
      readCycle(1'b0);
      checkOutput("drain_count", 64'(rd_acc), 64'(target));
   endtask

   // Write-side observer: every accepted write must be legal, land at the
   // next sequential address, and is recorded into the RAM model.
   task automatic monitorWrite();
      forever begin
         @(negedge wrclock);
         if (wr_rst) begin
            wr_acc = 0;
         end else begin
            checkOutput("full_and_wen_allow", 64'(bus.full & bus.wen_allow), 64'(0));
            if (bus.wen_allow) begin
               checkOutput("waddr", 64'(bus.waddr), 64'(wr_acc % DEPTH));
               checkOutput("no_overflow", 64'((wr_acc - rd_acc) < DEPTH), 64'(1));
               mem[bus.waddr] = wdata;
               wr_acc++;
            end
         end
      end
   endtask

   // Read-side observer: every accepted read must return the next word in
   // write order, and raddr must point at the head (or the word after it).
   task automatic monitorRead();
      forever begin
         @(negedge rdclock);
         if (rd_rst) begin
            rd_acc = 0;
         end else begin
            checkOutput("empty_and_ren_allow", 64'(bus.empty & bus.ren_allow), 64'(0));
            if (bus.ren_allow) begin
               checkOutput("no_underflow", 64'(rd_acc < wr_acc), 64'(1));
               checkOutput("rdata", 64'(dout), 64'(dataFor(rd_acc)));
               checkOutput("raddr_ahead", 64'(bus.raddr), 64'((rd_acc + 1) % DEPTH));
               rd_acc++;
            end else begin
               checkOutput("raddr_hold", 64'(bus.raddr), 64'(rd_acc % DEPTH));
            end
         end
      end
   endtask

   // Random traffic in both domains until NRAND words have gone through.
   task automatic applyStimulus(input int words);
      fork
         begin
            int k;
            k = 0;
            while (wr_acc < words && k < 60000) begin
               writeCycle($urandom_range(0, 3) != 0);
               k++;
            end
            writeCycle(1'b0);
         end
         begin
            int k;
            k = 0;
            while (rd_acc < words && k < 30000) begin
               readCycle($urandom_range(0, 7) != 0);
               k++;
            end
            readCycle(1'b0);
         end
      join
      checkOutput("rand_wr_total", 64'(wr_acc), 64'(words));
      checkOutput("rand_rd_total", 64'(rd_acc), 64'(words));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      wr_acc       = 0;
      rd_acc       = 0;
      wr_rst       = 1'b1;
      rd_rst       = 1'b1;
      bus.wen      = 1'b0;
      bus.ren      = 1'b0;
      wdata        = '0;
      salt         = $urandom;

      fork
         monitorWrite();
         monitorRead();
         begin
            // Reset values.
            doReset();
            checkOutput("rst_empty", 64'(bus.empty), 64'(1));
            checkOutput("rst_alempty", 64'(bus.alempty), 64'(1));
            checkOutput("rst_full", 64'(bus.full), 64'(0));
            checkOutput("rst_alfull", 64'(bus.alfull), 64'(0));
            checkOutput("rst_wr_deep", 64'(bus.wr_deep), 64'(0));
            checkOutput("rst_rd_deep", 64'(bus.rd_deep), 64'(0));
            checkOutput("rst_raddr", 64'(bus.raddr), 64'(0));

            // One word: empty falls on the third rdclock edge after the write.
            writeCycle(1'b1);
            @(posedge wrclock);
            #1;
            bus.wen = 1'b0;
            n = 0;
            do begin
               readCycle(1'b0);
               n++;
            end while (bus.empty && n < 10);
            checkOutput("empty_latency", 64'(n), 64'(3));
            checkOutput("one_rd_deep", 64'(bus.rd_deep), 64'(1));
            checkOutput("one_alempty", 64'(bus.alempty), 64'(1));
            readCycle(1'b1);
            checkOutput("one_ren_allow", 64'(bus.ren_allow), 64'(1));
            @(posedge rdclock);
            #1;
            bus.ren = 1'b0;
            #1;
            checkOutput("one_empty_again", 64'(bus.empty), 64'(1));
            checkOutput("one_rd_deep_zero", 64'(bus.rd_deep), 64'(0));

            // Fill up: alfull at 15, full at 16, 17th request refused.
            doReset();
            for (int i = 0; i < 15; i++) writeCycle(1'b1);
            writeCycle(1'b0);
            checkOutput("w15_alfull", 64'(bus.alfull), 64'(1));
            checkOutput("w15_wr_deep", 64'(bus.wr_deep), 64'(15));
            checkOutput("w15_full", 64'(bus.full), 64'(0));
            writeCycle(1'b1);
            writeCycle(1'b0);
            checkOutput("w16_full", 64'(bus.full), 64'(1));
            checkOutput("w16_wr_deep", 64'(bus.wr_deep), 64'(15));
            writeCycle(1'b1);
            checkOutput("w17_wen_allow", 64'(bus.wen_allow), 64'(0));
            checkOutput("w17_waddr", 64'(bus.waddr), 64'(0));
            writeCycle(1'b0);

            // Wrap: drain 16, write 16 more, full again, drain all 32.
            drainTo(16);
            fillTo(32);
            repeat (2) writeCycle(1'b0);
            checkOutput("wrap_full", 64'(bus.full), 64'(1));
            checkOutput("wrap_waddr", 64'(bus.waddr), 64'(0));
            drainTo(32);
            repeat (2) readCycle(1'b0);
            checkOutput("wrap_empty", 64'(bus.empty), 64'(1));
            checkOutput("wrap_rd_deep", 64'(bus.rd_deep), 64'(0));

            // Show-ahead addressing.
            doReset();
            writeCycle(1'b1);
            writeCycle(1'b1);
            writeCycle(1'b0);
            n = 0;
            while (bus.empty && n < 20) begin
               readCycle(1'b0);
               n++;
            end
            checkOutput("sa_not_empty", 64'(bus.empty), 64'(0));
            checkOutput("sa_raddr_idle", 64'(bus.raddr), 64'(0));
            @(posedge rdclock);
            #1;
            bus.ren = 1'b1;
            #1;
            checkOutput("sa_raddr_comb", 64'(bus.raddr), 64'(1));
            @(posedge rdclock);
            #1;
            bus.ren = 1'b0;
            #1;
            checkOutput("sa_raddr_next", 64'(bus.raddr), 64'(1));
            drainTo(2);

            // Random asynchronous traffic.
            doReset();
            applyStimulus(NRAND);
         end
      join_any

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
